// File: rtl/ser_word_collector_pkg.sv
// Shared definitions for the serial word collector: FSM encoding and
// the active-low 7-segment lookup table, bit order {g,f,e,d,c,b,a}.
package ser_word_collector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/ser_word_collector_hex_to_seg.sv
// Hex digit to active-low 7-segment pattern, purely combinational.
module hex_to_seg
    import ser_word_collector_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ser_word_collector.sv
// Collects a framed serial bit stream into WORD_W-bit words (MSB first),
// flags bursts that end mid-word, and shows the word count on a 7-seg digit.
module ser_word_collector
    import ser_word_collector_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    input  logic              serInValid,
    output logic [WORD_W-1:0] wordOut,
    output logic              wordValid,
    output logic              shortErr,
    output logic [3:0]        wordCnt,
    output logic [6:0]        seg_out
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    // Only the first WORD_W-1 bits are held; the final bit goes straight into wordOut.
    localparam int SHREG_W = WORD_W - 1;

    state_t             state, state_next;
    logic [SHREG_W-1:0] shreg, shreg_next;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [WORD_W-1:0]  word_out_next;
    logic               word_valid_next;
    logic               short_err_next;
    logic [3:0]         word_cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            wordOut   <= '0;
            wordValid <= 1'b0;
            shortErr  <= 1'b0;
            wordCnt   <= 4'd0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            wordOut   <= word_out_next;
            wordValid <= word_valid_next;
            shortErr  <= short_err_next;
            wordCnt   <= word_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        word_out_next   = wordOut;
        word_valid_next = 1'b0;
        short_err_next  = 1'b0;
        word_cnt_next   = wordCnt;

        unique case (state)
            IDLE: begin
                if (serInValid) begin
                    shreg_next   = SHREG_W'({shreg, serIn});
                    bit_cnt_next = CNT_W'(1);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (serInValid) begin
                    shreg_next = SHREG_W'({shreg, serIn});
                    if (bit_cnt == LAST_BIT) begin
                        word_out_next   = {shreg, serIn};
                        word_valid_next = 1'b1;
                        word_cnt_next   = wordCnt + 4'd1;
                        bit_cnt_next    = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end else if (bit_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    // Burst ended mid-word: drop the partial bits.
                    state_next     = ERR;
                    short_err_next = 1'b1;
                    shreg_next     = '0;
                    bit_cnt_next   = '0;
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .hex (wordCnt),
        .seg (seg_out)
    );

endmodule

// File: tb/tb_ser_word_collector.sv
// Directed self-checking bench for ser_word_collector (WORD_W = 8).
module tb_ser_word_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       serIn;
    logic       serInValid;
    logic [7:0] wordOut;
    logic       wordValid;
    logic       shortErr;
    logic [3:0] wordCnt;
    logic [6:0] seg_out;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [15:0] pair;
    logic [7:0]  word;

    ser_word_collector #(.WORD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .serIn      (serIn),
        .serInValid (serInValid),
        .wordOut    (wordOut),
        .wordValid  (wordValid),
        .shortErr   (shortErr),
        .wordCnt    (wordCnt),
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one bit, let the DUT sample it, then settle just past the edge.
    task automatic applyStimulus(input logic b, input logic v);
        serIn      = b;
        serInValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) applyStimulus(w[i], 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        serIn      = 1'b0;
        serInValid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wordOut", 32'(wordOut), 32'h00);
        checkOutput("reset_wordValid", 32'(wordValid), 32'h0);
        checkOutput("reset_shortErr", 32'(shortErr), 32'h0);
        checkOutput("reset_wordCnt", 32'(wordCnt), 32'h0);
        checkOutput("reset_seg", 32'(seg_out), 32'(7'b1000000));
        rst = 1'b1;

        // Single word 8'hB2
        word = 8'hB2;
        for (int i = 7; i >= 1; i--) applyStimulus(word[i], 1'b1);
        checkOutput("single_no_early_valid", 32'(wordValid), 32'h0);
        applyStimulus(word[0], 1'b1);
        checkOutput("single_wordValid", 32'(wordValid), 32'h1);
        checkOutput("single_wordOut", 32'(wordOut), 32'hB2);
        checkOutput("single_wordCnt", 32'(wordCnt), 32'h1);
        checkOutput("single_seg", 32'(seg_out), 32'(7'b1111001));
        applyStimulus(1'b0, 1'b0);
        checkOutput("single_pulse_ends", 32'(wordValid), 32'h0);
        checkOutput("boundary_no_shortErr", 32'(shortErr), 32'h0);

        // Back-to-back A5 then 3C, no gap
        pair   = 16'hA53C;
        pulses = 0;
        for (int i = 15; i >= 0; i--) begin
            applyStimulus(pair[i], 1'b1);
            if (i == 8) begin
                checkOutput("b2b_first_valid", 32'(wordValid), 32'h1);
                checkOutput("b2b_first_word", 32'(wordOut), 32'hA5);
            end else if (i == 0) begin
                checkOutput("b2b_second_valid", 32'(wordValid), 32'h1);
                checkOutput("b2b_second_word", 32'(wordOut), 32'h3C);
            end else begin
                pulses += int'(wordValid);
            end
        end
        checkOutput("b2b_stray_pulses", 32'(pulses), 32'h0);
        checkOutput("b2b_wordCnt", 32'(wordCnt), 32'h3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("b2b_no_shortErr", 32'(shortErr), 32'h0);

        // Short burst of 5 bits, then a bit offered during ERR must be lost
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("short_no_valid_mid", 32'(wordValid), 32'h0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("short_shortErr", 32'(shortErr), 32'h1);
        checkOutput("short_no_wordValid", 32'(wordValid), 32'h0);
        checkOutput("short_wordOut_kept", 32'(wordOut), 32'h3C);
        checkOutput("short_wordCnt_kept", 32'(wordCnt), 32'h3);
        applyStimulus(1'b1, 1'b1);
        checkOutput("short_err_one_cycle", 32'(shortErr), 32'h0);
        checkOutput("short_err_no_valid", 32'(wordValid), 32'h0);
        word   = 8'h5A;
        pulses = 0;
        for (int i = 7; i >= 1; i--) begin
            applyStimulus(word[i], 1'b1);
            pulses += int'(wordValid);
        end
        checkOutput("after_err_no_early", 32'(pulses), 32'h0);
        applyStimulus(word[0], 1'b1);
        checkOutput("after_err_valid", 32'(wordValid), 32'h1);
        checkOutput("after_err_word", 32'(wordOut), 32'h5A);
        checkOutput("after_err_wordCnt", 32'(wordCnt), 32'h4);
        applyStimulus(1'b0, 1'b0);

        // Wrap: reset, then 17 consecutive words
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("wrap_start_cnt", 32'(wordCnt), 32'h0);
        for (int k = 0; k < 17; k++) begin
            sendWord(8'(k * 37 + 1));
            checkOutput("wrap_word_valid", 32'(wordValid), 32'h1);
            if (k == 14) begin
                checkOutput("wrap_cnt15", 32'(wordCnt), 32'hF);
                checkOutput("wrap_seg15", 32'(seg_out), 32'(7'b0001110));
            end else if (k == 15) begin
                checkOutput("wrap_cnt0", 32'(wordCnt), 32'h0);
                checkOutput("wrap_seg0", 32'(seg_out), 32'(7'b1000000));
            end else if (k == 16) begin
                checkOutput("wrap_cnt1", 32'(wordCnt), 32'h1);
                checkOutput("wrap_seg1", 32'(seg_out), 32'(7'b1111001));
                checkOutput("wrap_last_word", 32'(wordOut), 32'h51);
            end
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("wrap_end_no_valid", 32'(wordValid), 32'h0);
        checkOutput("wrap_end_no_err", 32'(shortErr), 32'h0);

        // Reset after 4 bits of a word
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_async_cnt", 32'(wordCnt), 32'h0);
        checkOutput("midrst_async_word", 32'(wordOut), 32'h00);
        checkOutput("midrst_async_seg", 32'(seg_out), 32'(7'b1000000));
        @(posedge clk);
        #1;
        serInValid = 1'b0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_no_shortErr_a", 32'(shortErr), 32'h0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_no_shortErr_b", 32'(shortErr), 32'h0);
        sendWord(8'hC3);
        checkOutput("midrst_word_valid", 32'(wordValid), 32'h1);
        checkOutput("midrst_word", 32'(wordOut), 32'hC3);
        checkOutput("midrst_wordCnt", 32'(wordCnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_word_collector.md
SER_WORD_COLLECTOR -- requirements
Module: ser_word_collector

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per assembled word (legal range 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port serIn  input  1  serial data bit from upstream serOut, sampled only when serInValid=1.
REQ-005 SHALL have port serInValid  input  1  upstream serOutValid; high for each cycle carrying a valid bit.
REQ-006 SHALL have port wordOut  output  WORD_W  last completed word, first-received bit in MSB.
REQ-007 SHALL have port wordValid  output  1  one-cycle pulse marking a new wordOut.
REQ-008 SHALL have port shortErr  output  1  one-cycle pulse when a burst ends mid-word.
REQ-009 SHALL have port wordCnt  output  4  count of completed words, modulo 16.
REQ-010 SHALL have port seg_out  output  7  wordCnt as a hex digit on a 7-segment display, active-low, bit order {g,f,e,d,c,b,a}.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, ERR.
REQ-012 In IDLE with serInValid=1, SHALL shift serIn into the shift register, set bitCnt=1 and go to SHIFT; otherwise it SHALL stay in IDLE.
REQ-013 In SHIFT with serInValid=1, SHALL shift serIn into the LSB (shreg <= {shreg[WORD_W-2:0], serIn}) and increment bitCnt.
REQ-014 On the edge capturing bit WORD_W, SHALL load wordOut with the complete word, raise wordValid for exactly the next cycle, increment wordCnt, clear bitCnt and stay in SHIFT.
REQ-015 In SHIFT with serInValid=0 and bitCnt=0 (word boundary), SHALL return to IDLE with no error.
REQ-016 In SHIFT with serInValid=0 and 0<bitCnt<WORD_W, SHALL go to ERR, discard the partial word and leave wordOut and wordCnt unchanged.
REQ-017 ERR SHALL last exactly one cycle with shortErr=1, then go to IDLE.
REQ-018 ERR SHALL ignore serIn and serInValid; a bit presented during ERR is lost.
REQ-019 Latency SHALL be one cycle: wordValid is high in the cycle immediately after the edge that sampled the final bit.
REQ-020 Back-to-back words with serInValid held high SHALL be assembled with no gap cycles, and wordValid SHALL pulse every WORD_W cycles.
REQ-021 wordCnt SHALL wrap from 15 to 0 without a flag.
REQ-022 seg_out SHALL be a combinational decode of wordCnt for digits 0-9 and A-F (e.g. 0 -> 7'b1000000, 1 -> 7'b1111001).
REQ-023 wordValid and shortErr SHALL never be high in the same cycle.

Reset
REQ-024 While rst=0, SHALL hold FSM in IDLE, with shreg=0, bitCnt=0, wordOut=0, wordValid=0, shortErr=0, wordCnt=0 and seg_out=7'b1000000, independent of clk.
REQ-025 Reset mid-word SHALL discard the partial word with no shortErr pulse.
REQ-026 After rst returns to 1, the first valid bit SHALL be accepted on the first rising clk edge.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, SHIFT, ERR) and the 16-entry hex-to-segment constant table.
REQ-028 The segment decode SHALL be a separate sub-module, hex_to_seg (4-bit in, 7-bit active-low out), instantiated once.
REQ-029 The total RTL SHALL be 120-400 lines, with no latches and no clock gating.

Verification
REQ-030 Reset check: rst=0 for 2 cycles, then 1 -> all outputs 0 and seg_out=7'b1000000.
REQ-031 Single word: serInValid=1 for 8 cycles with serIn=1,0,1,1,0,0,1,0 -> wordOut=8'hB2, one wordValid pulse on cycle 9, wordCnt=1, seg_out=7'b1111001.
REQ-032 Back-to-back words: 16 valid cycles carrying 8'hA5 then 8'h3C -> two wordValid pulses 8 cycles apart, wordOut A5 then 3C, wordCnt=2.
REQ-033 Short burst: 5 valid bits then serInValid=0 -> shortErr pulses once, no wordValid, wordOut and wordCnt unchanged.
REQ-034 Wrap: 17 consecutive words -> wordCnt=1 and seg_out=7'b1111001.
REQ-035 Reset mid-word: rst=0 after 4 bits -> no shortErr, next full word assembles correctly.
